// File: rtl/spi_reg_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_responder_if
// Brief   : SPI pin bundle between an SPI initiator and spi_reg_responder.
// Revision: 1.0
// ============================================================================
interface spi_reg_responder_if;
  logic SCLK;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic MISO_OE;

  modport master (output SCLK, output SS_n, output MOSI, input MISO, input MISO_OE);
  modport slave  (input SCLK, input SS_n, input MOSI, output MISO, output MISO_OE);
endinterface
`default_nettype wire

// File: rtl/spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_responder
// Brief   : Oversampled SPI mode-0 responder with a 32 x 8 register file and a
//           local fabric port. Define SPI_REG_RESPONDER_IRQ_EN for HIRQ/HIEN.
// Revision: 1.0
// ============================================================================
module spi_reg_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter int         STATUS_ADDR = 25,
  parameter int         REV_ADDR    = 18,
  parameter logic [7:0] REV_VALUE   = 8'h13
) (
  input  logic               Clk,
  input  logic               Reset,
  spi_reg_responder_if.slave spi,
  input  logic [4:0]         loc_addr,
  input  logic               loc_we,
  input  logic [7:0]         loc_wdata,
  output logic [7:0]         loc_rdata,
  output logic               wr_strobe,
  output logic [4:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               INT_n
);
  localparam logic [4:0] STATUS_A = 5'(STATUS_ADDR);
  localparam logic [4:0] REV_A    = 5'(REV_ADDR);
`ifdef SPI_REG_RESPONDER_IRQ_EN
  localparam logic [4:0] HIRQ_A   = 5'd25;
  localparam logic [4:0] HIEN_A   = 5'd26;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_in_q, shift_in_d;
  logic [7:0]  shift_in_nx;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [4:0]  addr_q, addr_d;
  logic        dir_wr_q, dir_wr_d;
  logic        preload_q, preload_d;
  logic        miso_oe_q, miso_oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        int_n_q, int_n_d;
  logic [7:0]  regs_q [32];
  logic [7:0]  regs_d [32];
  logic        spi_we, loc_ok;
  logic [7:0]  status_val, rd_val;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi.SS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    ss_prev_d   = ss_sync_q[SYNC_STAGES-1];
  end

  assign sclk_rise   =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_prev_q;
  assign ss_rise     =  ss_sync_q[SYNC_STAGES-1]   & ~ss_prev_q;
  assign ss_fall     = ~ss_sync_q[SYNC_STAGES-1]   &  ss_prev_q;
  assign mosi_s      =  mosi_sync_q[SYNC_STAGES-1];
  assign shift_in_nx = {shift_in_q, mosi_s};

  // The revision register has no storage behind it; reads always see REV_VALUE.
  assign status_val = (STATUS_A == REV_A) ? REV_VALUE : regs_q[STATUS_A];
  assign rd_val     = (addr_q == REV_A)   ? REV_VALUE : regs_q[addr_q];
  assign loc_rdata  = (loc_addr == REV_A) ? REV_VALUE : regs_q[loc_addr];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    dir_wr_d    = dir_wr_q;
    preload_d   = preload_q;
    miso_oe_d   = miso_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    spi_we      = 1'b0;
    if (ss_rise) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      shift_out_d = 8'h00;
      miso_oe_d   = 1'b0;
      preload_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_fall) begin
            shift_out_d = status_val;
            miso_oe_d   = 1'b1;
            bit_cnt_d   = 3'd0;
            state_d     = ST_CMD;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            shift_in_d = shift_in_nx[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d    = shift_in_nx[7:3];
              dir_wr_d  = shift_in_nx[1];
              preload_d = ~shift_in_nx[1];
              state_d   = ST_DATA;
            end
          end else if (sclk_fall) begin
            shift_out_d = {shift_out_q[6:0], 1'b0};
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            shift_in_d = shift_in_nx[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (dir_wr_q) begin
                spi_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                wr_data_d   = shift_in_nx;
              end else begin
                preload_d = 1'b1;
              end
              addr_d = addr_q + 5'd1;
            end
          end else if (sclk_fall) begin
            if (preload_q) begin
              shift_out_d = rd_val;
              preload_d   = 1'b0;
            end else if (dir_wr_q) begin
              shift_out_d = 8'h00;
            end else begin
              shift_out_d = {shift_out_q[6:0], 1'b0};
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    regs_d = regs_q;
    // A local write loses to an SPI write landing on the same address in the same cycle.
    loc_ok = loc_we && (loc_addr != REV_A) && !(spi_we && (addr_q == loc_addr));
`ifdef SPI_REG_RESPONDER_IRQ_EN
    if (loc_ok && (loc_addr != HIRQ_A)) regs_d[loc_addr] = loc_wdata;
    if (spi_we && (addr_q != REV_A) && (addr_q != HIRQ_A)) regs_d[addr_q] = shift_in_nx;
    regs_d[HIRQ_A] = (regs_q[HIRQ_A] & ~((spi_we && (addr_q == HIRQ_A)) ? shift_in_nx : 8'h00))
                   | ((loc_we && (loc_addr == HIRQ_A)) ? loc_wdata : 8'h00);
    int_n_d = ~|(regs_q[HIRQ_A] & regs_q[HIEN_A]);
`else
    if (loc_ok) regs_d[loc_addr] = loc_wdata;
    if (spi_we && (addr_q != REV_A)) regs_d[addr_q] = shift_in_nx;
    int_n_d = 1'b1;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 7'd0;
      shift_out_q <= 8'h00;
      addr_q      <= 5'd0;
      dir_wr_q    <= 1'b0;
      preload_q   <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'h00;
      int_n_q     <= 1'b1;
      for (int i = 0; i < 32; i++) regs_q[i] <= 8'h00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      dir_wr_q    <= dir_wr_d;
      preload_q   <= preload_d;
      miso_oe_q   <= miso_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      int_n_q     <= int_n_d;
      regs_q      <= regs_d;
    end
  end

  assign spi.MISO    = shift_out_q[7];
  assign spi.MISO_OE = miso_oe_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign INT_n       = int_n_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_reg_responder
// Brief   : Directed and randomized SPI/local traffic checked against a
//           register-file model of spi_reg_responder.
// Revision: 1.0
// ============================================================================
module tb_spi_reg_responder;
  localparam int         SYNC     = 2;
  localparam int         HALF     = 5;      // Clk cycles per SCLK half period (5 MHz)
  localparam logic [4:0] STATUS_A = 5'd25;
  localparam logic [4:0] REV_A    = 5'd18;
  localparam logic [7:0] REV_V    = 8'h13;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] loc_addr;
  logic       loc_we;
  logic [7:0] loc_wdata;
  logic [7:0] loc_rdata;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       INT_n;

  spi_reg_responder_if spi_bus();

  always #10 Clk = ~Clk;

  spi_reg_responder #(
    .SYNC_STAGES(SYNC), .STATUS_ADDR(25), .REV_ADDR(18), .REV_VALUE(8'h13)
  ) dut (
    .Clk(Clk), .Reset(Reset), .spi(spi_bus),
    .loc_addr(loc_addr), .loc_we(loc_we), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .INT_n(INT_n)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  m_regs [32];
  logic [12:0] exp_q [$];
  logic [12:0] obs_q [$];
  logic [12:0] exp_last = 13'd0;

  always @(negedge Clk) if (wr_strobe === 1'b1) obs_q.push_back({wr_addr, wr_data});

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] m_rd(input logic [4:0] a);
    return (a == REV_A) ? REV_V : m_regs[a];
  endfunction

  function automatic void m_loc_write(input logic [4:0] a, input logic [7:0] d);
    if (a == REV_A) return;
`ifdef SPI_REG_RESPONDER_IRQ_EN
    if (a == 5'd25) begin m_regs[25] = m_regs[25] | d; return; end
`endif
    m_regs[a] = d;
  endfunction

  function automatic void m_spi_write(input logic [4:0] a, input logic [7:0] d);
    if (a == REV_A) return;
`ifdef SPI_REG_RESPONDER_IRQ_EN
    if (a == 5'd25) begin m_regs[25] = m_regs[25] & ~d; return; end
`endif
    m_regs[a] = d;
  endfunction

  function automatic void m_collide(input logic [4:0] sa, input logic [7:0] sd,
                                    input logic [4:0] la, input logic [7:0] ld);
`ifdef SPI_REG_RESPONDER_IRQ_EN
    if (sa == 5'd25 && la == 5'd25) begin m_regs[25] = (m_regs[25] & ~sd) | ld; return; end
`endif
    if (sa != la) m_loc_write(la, ld);
    m_spi_write(sa, sd);
  endfunction

  task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge Clk); loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    @(negedge Clk); loc_we = 1'b0;
    m_loc_write(a, d);
  endtask

  task automatic check_regs();
    for (int a = 0; a < 32; a++) begin
      @(negedge Clk); loc_addr = 5'(a); #1;
      check_val($sformatf("reg%0d", a), loc_rdata, m_rd(5'(a)));
    end
  endtask

  task automatic check_int();
`ifdef SPI_REG_RESPONDER_IRQ_EN
    check_val("int_n", INT_n, ~|(m_regs[25] & m_regs[26]));
`else
    check_val("int_n", INT_n, 1);
`endif
  endtask

  // Mode-0 initiator; coll_bit >= 0 pulses loc_we in the Clk where that rise is acted on.
  task automatic spi_xfer(input logic [7:0] tx [8], input int nbits, input int coll_bit,
                          input logic [4:0] ca, input logic [7:0] cd, output logic [7:0] rx [8]);
    for (int i = 0; i < 8; i++) rx[i] = 8'h00;
    @(negedge Clk); spi_bus.SS_n = 1'b0;
    repeat (HALF + SYNC + 2) @(negedge Clk);
    check_val("oe_on", spi_bus.MISO_OE, 1);
    for (int b = 0; b < nbits; b++) begin
      spi_bus.MOSI = tx[b/8][7-(b%8)];
      repeat (HALF) @(negedge Clk);
      rx[b/8][7-(b%8)] = spi_bus.MISO;
      spi_bus.SCLK = 1'b1;
      if (b == coll_bit) begin
        repeat (SYNC) @(negedge Clk);
        loc_addr = ca; loc_wdata = cd; loc_we = 1'b1;
        @(negedge Clk); loc_we = 1'b0;
        repeat (HALF - SYNC - 1) @(negedge Clk);
      end else begin
        repeat (HALF) @(negedge Clk);
      end
      spi_bus.SCLK = 1'b0;
    end
    repeat (HALF) @(negedge Clk);
    spi_bus.SS_n = 1'b1; spi_bus.MOSI = 1'b0;
    repeat (SYNC + 2) @(negedge Clk);
    check_val("oe_off", spi_bus.MISO_OE, 0);
    check_val("miso_idle", spi_bus.MISO, 0);
    repeat (HALF) @(negedge Clk);
  endtask

  task automatic do_txn(input logic [7:0] tx [8], input int nbits, input int coll_byte,
                        input logic [4:0] ca, input logic [7:0] cd);
    logic [7:0] rx [8];
    logic [7:0] exp_rx [8];
    logic [4:0] a;
    logic       wr;
    int         full;
    int         cbit;
    full = nbits / 8;
    a    = tx[0][7:3];
    wr   = tx[0][1];
    cbit = (wr && coll_byte > 0 && coll_byte < full) ? coll_byte * 8 + 7 : -1;
    for (int i = 0; i < 8; i++) exp_rx[i] = 8'h00;
    exp_rx[0] = m_rd(STATUS_A);
    for (int k = 1; k < full; k++) begin
      if (wr) begin
        if (k * 8 + 7 == cbit) m_collide(a, tx[k], ca, cd);
        else m_spi_write(a, tx[k]);
        exp_q.push_back({a, tx[k]});
        exp_last = {a, tx[k]};
      end else begin
        exp_rx[k] = m_rd(a);
      end
      a = a + 5'd1;
    end
    spi_xfer(tx, nbits, cbit, ca, cd, rx);
    for (int k = 0; k < full; k++)
      check_val($sformatf("miso_byte%0d", k), rx[k], exp_rx[k]);
    check_val("strobe_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check_val("strobe_addr_data", obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    check_val("wr_addr", wr_addr, exp_last[12:8]);
    check_val("wr_data", wr_data, exp_last[7:0]);
    check_regs();
    check_int();
  endtask

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] tx [8];
    Reset = 1'b1;
    spi_bus.SCLK = 1'b0; spi_bus.SS_n = 1'b1; spi_bus.MOSI = 1'b0;
    loc_addr = 5'd0; loc_we = 1'b0; loc_wdata = 8'h00;
    for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    for (int i = 0; i < 8; i++) tx[i] = 8'h00;
    repeat (3) @(negedge Clk);
    check_val("rst_miso", spi_bus.MISO, 0);
    check_val("rst_oe", spi_bus.MISO_OE, 0);
    check_val("rst_strobe", wr_strobe, 0);
    check_val("rst_wr_addr", wr_addr, 0);
    check_val("rst_wr_data", wr_data, 0);
    check_val("rst_int_n", INT_n, 1);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check_regs();

    // Write 0x5C to addr 20 with a non-zero status register.
    loc_write(5'd25, 8'h3C);
    tx[0] = 8'hA2; tx[1] = 8'h5C;
    do_txn(tx, 16, -1, 5'd0, 8'h00);

    // Read the revision register, then try to overwrite it locally.
    tx[0] = 8'h90; tx[1] = 8'h00;
    do_txn(tx, 16, -1, 5'd0, 8'h00);
    loc_write(REV_A, 8'hFF);
    check_regs();

    // Burst write wrapping from 31 to 0.
    tx[0] = 8'hFA; tx[1] = 8'h11; tx[2] = 8'h22; tx[3] = 8'h33;
    do_txn(tx, 32, -1, 5'd0, 8'h00);

    // Burst read across the wrap.
    tx[0] = 8'hF9; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h00;
    do_txn(tx, 32, -1, 5'd0, 8'h00);

    // Abort after 4 data bits.
    tx[0] = 8'h3A; tx[1] = 8'hC3;
    do_txn(tx, 12, -1, 5'd0, 8'h00);

    // Command-only transaction.
    tx[0] = 8'h28;
    do_txn(tx, 8, -1, 5'd0, 8'h00);

    // Same-address collision: SPI wins.
    tx[0] = 8'h2A; tx[1] = 8'hAA;
    do_txn(tx, 16, 1, 5'd5, 8'h55);

    // Different-address collision: both land.
    tx[0] = 8'h4A; tx[1] = 8'h96;
    do_txn(tx, 16, 1, 5'd10, 8'h69);

`ifdef SPI_REG_RESPONDER_IRQ_EN
    loc_write(5'd26, 8'h01);
    loc_write(5'd25, 8'h01);
    repeat (2) @(negedge Clk);
    check_val("int_asserted", INT_n, 0);
    tx[0] = 8'hCA; tx[1] = 8'h01;
    do_txn(tx, 16, -1, 5'd0, 8'h00);
`endif

    for (int t = 0; t < 30; t++) begin
      int         nl;
      int         nb;
      int         part;
      int         cb;
      logic [4:0] ca;
      logic [7:0] cd;
      nl = $urandom_range(0, 2);
      for (int j = 0; j < nl; j++) loc_write(5'($urandom_range(0, 31)), 8'($urandom));
      for (int k = 0; k < 8; k++) tx[k] = 8'($urandom);
      nb   = $urandom_range(0, 3);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      cb   = -1;
      ca   = 5'($urandom_range(0, 31));
      cd   = 8'($urandom);
      if (tx[0][1] && nb > 0 && $urandom_range(0, 2) == 0) begin
        cb = $urandom_range(1, nb);
        if ($urandom_range(0, 1) == 0) ca = tx[0][7:3] + 5'(cb - 1);
      end
      do_txn(tx, 8 * (nb + 1) + part, cb, ca, cd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 responder (slave) exposing a 32 x 8 register file to an external SPI initiator.
- Uses MAX3421E-style command framing, so the same initiator firmware that drives the USB host chip can drive this block. The SPI master sits on the SoC side; this block is the far end of that link.
- SPI pins are oversampled in the system clock domain.
- A local port lets fabric logic (keycode/ball logic) read and update the registers.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCLK, SS_n and MOSI (min 2).
- STATUS_ADDR, 25, register returned on MISO during the command byte.
- REV_ADDR, 18, read-only revision register address.
- REV_VALUE, 8'h13, constant read at REV_ADDR.

Ports:
- Clk  in  1  system clock, 50 MHz; must be >= 8x SCLK.
- Reset  in  1  asynchronous, active-high.
- SCLK  in  1  SPI clock from the initiator, idle low.
- SS_n  in  1  chip select, active-low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- MISO_OE  out  1  1 = drive MISO pin; top level tristates when 0.
- loc_addr  in  5  local port address.
- loc_we  in  1  local write enable, single-cycle.
- loc_wdata  in  8  local write data.
- loc_rdata  out  8  combinational read of reg[loc_addr].
- wr_strobe  out  1  one-cycle pulse on each completed SPI write.
- wr_addr  out  5  address of the last SPI write.
- wr_data  out  8  data of the last SPI write.
- INT_n  out  1  interrupt, active-low.

Behaviour:
- Reset (async) state:
  - All registers 0, except REV_ADDR, which always reads REV_VALUE.
  - MISO=0, MISO_OE=0, wr_strobe=0, wr_addr=0, wr_data=0, INT_n=1, FSM=IDLE, bit count=0.
  - Reset mid-transaction aborts it with no write.
- Input sampling:
  - SCLK, SS_n and MOSI pass through SYNC_STAGES flops.
  - Edge detect uses one further flop, giving rise/fall pulses delayed SYNC_STAGES+1 Clk cycles.
  - All logic runs on Clk only; SCLK is never used as a clock.
- FSM states:
  - IDLE:
    - SS_n synchronized falling edge -> load shift-out register with reg[STATUS_ADDR]; MISO = its bit 7; MISO_OE=1 -> CMD.
  - CMD:
    - SCLK rise: shift in MOSI.
    - SCLK fall: shift out next bit.
    - After 8th rise, decode cmd: addr=cmd[7:3], dir=cmd[1] (1=write), cmd[2] and cmd[0] ignored.
    - Read (dir=0): on the following SCLK fall, preload reg[addr] and drive its bit 7 -> DATA.
    - Write (dir=1): -> DATA, with MISO driving 0s.
  - DATA:
    - Eight rises complete one byte.
    - Write: on the 8th rise, store the byte to reg[addr] (ignored at REV_ADDR) and pulse wr_strobe with wr_addr/wr_data; the write is visible via loc_rdata the next Clk.
    - Both directions: addr increments mod 32 (31 wraps to 0); the next read byte is preloaded on the next fall; stay in DATA.
  - Any state:
    - SS_n synchronized rising edge -> IDLE, MISO_OE=0, MISO=0; a partial byte is discarded with no write and no strobe.
- Collisions:
  - SPI write and loc_we to the same address in the same Clk: SPI write wins, local write dropped.
  - Different addresses: both occur.
  - Local writes to REV_ADDR are ignored.
- Read data is captured at preload time; a later local write does not alter bits already being shifted.
- SCLK edges while SS_n is high are ignored.
- Transactions of 8 bits (command only) are legal: no data is transferred.

Optional Feature:
- Macro SPI_REG_RESPONDER_IRQ_EN.
- Defined:
  - reg[25] is HIRQ, reg[26] is HIEN.
  - Local writes to HIRQ set bits (OR-in).
  - SPI writes to HIRQ clear the bits written as 1 (write-1-to-clear).
  - INT_n = ~|(HIRQ & HIEN), registered, one Clk latency.
  - If a set and a clear of the same bit hit the same Clk, set wins.
- Undefined: reg[25] and reg[26] are plain storage; INT_n tied to 1.

Test Plan:
- SPI write: SCLK=5 MHz, SS_n low, send 8'hA2 (addr 20, write) then 8'h5C, SS_n high -> reg[20]=8'h5C, one wr_strobe with wr_addr=20, wr_data=8'h5C; MISO returns reg[25] during the command byte.
- SPI read of REV_ADDR: send 8'h90 (addr 18, read) + dummy byte -> MISO second byte = 8'h13; a local write of 8'hFF to addr 18 leaves it at 8'h13.
- Burst wrap: write cmd to addr 31 with 3 data bytes 11,22,33 -> reg[31]=11, reg[0]=22, reg[1]=33, three strobes.
- Abort: SS_n rises after 4 data bits -> no register change, no strobe, MISO_OE=0 within SYNC_STAGES+2 Clk.
- Collision: SPI write 8'hAA to addr 5 completes in the same Clk as loc_we 8'h55 to addr 5 -> reg[5]=8'hAA.
- IRQ_EN: HIEN=8'h01, local write HIRQ=8'h01 -> INT_n=0 next Clk; SPI write 8'h01 to addr 25 -> HIRQ=0, INT_n=1.
